// File: rtl/helper_gen.sv
// helper_gen: enrollment helper data for the RO PUF fuzzy extractor.
// The secret is systematically BCH-encoded (t=8, GF(2^9)) by a byte-serial LFSR and XORed with the response.
module helper_gen #(
    parameter int N    = 264,
    parameter int K    = 192,
    parameter int BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] response,
    input  logic [K-1:0] secret,
    output logic [N-1:0] helper,
    output logic         busy,
    output logic         ready
);
    localparam int P      = N - K;
    localparam int NSTEPS = K / BITS;
    localparam int CW     = $clog2(NSTEPS + 1);

    function automatic logic [8:0] gf_mul(input logic [8:0] a, input logic [8:0] b);
        logic [8:0] r;
        logic [8:0] aa;
        r  = 9'd0;
        aa = a;
        for (int i = 0; i < 9; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[8] ? ({aa[7:0], 1'b0} ^ 9'h011) : {aa[7:0], 1'b0};
        end
        return r;
    endfunction

    // g(x) is the product of (x + alpha^r) over the cyclotomic cosets of 1,3,...,15.
    function automatic logic [71:0] gen_poly_calc();
        logic [8:0]  c [0:72];
        logic [8:0]  beta;
        logic [71:0] g;
        for (int j = 0; j <= 72; j++) c[j] = 9'd0;
        c[0] = 9'd1;
        for (int m = 1; m < 16; m += 2) begin
            beta = 9'd1;
            for (int e = 0; e < m; e++) beta = gf_mul(beta, 9'd2);
            for (int k = 0; k < 9; k++) begin
                for (int j = 72; j > 0; j--) c[j] = c[j-1] ^ gf_mul(beta, c[j]);
                c[0] = gf_mul(beta, c[0]);
                beta = gf_mul(beta, beta);
            end
        end
        for (int j = 0; j < 72; j++) g[j] = c[j][0];
        return g;
    endfunction

    localparam logic [P-1:0] GEN_POLY = gen_poly_calc();

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [P-1:0]  lfsr_q, lfsr_d;
    logic [N-1:0]  resp_q, resp_d;
    logic [K-1:0]  sec_q, sec_d;
    logic [N-1:0]  helper_q, helper_d;
    logic          ready_q, ready_d;

    logic [K-1:0]    sec_shift;
    logic [BITS-1:0] byte_in;
    logic [P-1:0]    lfsr_step;
    logic            fb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        resp_d   = resp_q;
        sec_d    = sec_q;
        helper_d = helper_q;
        ready_d  = ready_q;

        sec_shift = sec_q << (BITS * int'(cnt_q));
        byte_in   = sec_shift[K-1 -: BITS];
        lfsr_step = lfsr_q;
        fb        = 1'b0;
        for (int i = BITS - 1; i >= 0; i--) begin
            fb        = byte_in[i] ^ lfsr_step[P-1];
            lfsr_step = {lfsr_step[P-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    resp_d  = response;
                    sec_d   = secret;
                    lfsr_d  = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ENC;
                end
            end
            ENC: begin
                // One extra cycle after the last byte registers the helper word.
                if (cnt_q == CW'(NSTEPS)) begin
                    helper_d = {resp_q[N-1:P] ^ sec_q, resp_q[P-1:0] ^ lfsr_q};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lfsr_q   <= '0;
            resp_q   <= '0;
            sec_q    <= '0;
            helper_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            resp_q   <= resp_d;
            sec_q    <= sec_d;
            helper_q <= helper_d;
            ready_q  <= ready_d;
        end
    end

    assign helper = helper_q;
    assign ready  = ready_q;
    assign busy   = (state_q == ENC);

endmodule

// File: tb/tb_helper_gen.sv
// Testbench for helper_gen: randomized requests scored against a long-division BCH model
// and a syndrome check computed from GF(2^9) tables.
module tb_helper_gen;
    localparam int N    = 264;
    localparam int K    = 192;
    localparam int P    = 72;
    localparam int BITS = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] response;
    logic [K-1:0] secret;
    logic [N-1:0] helper;
    logic         busy;
    logic         ready;

    always #5 clk = ~clk;

    helper_gen #(.N(N), .K(K), .BITS(BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .response (response),
        .secret   (secret),
        .helper   (helper),
        .busy     (busy),
        .ready    (ready)
    );

    typedef struct {
        logic [N-1:0] exp_helper;
        logic [N-1:0] resp;
        int           start_cycle;
    } txn_t;

    txn_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cycle    = 0;
    int           gf_exp [0:510];
    int           gf_log [0:511];
    logic [P:0]   g_full;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void build_field();
        int x;
        x = 1;
        for (int i = 0; i < 511; i++) begin
            gf_exp[i] = x;
            gf_log[x] = i;
            x = x << 1;
            if ((x & 512) != 0) x = x ^ 'h211;
        end
        gf_log[0] = 0;
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp[(gf_log[a] + gf_log[b]) % 511];
    endfunction

    // g(x) as the product of the binary minimal polynomials of alpha^1, alpha^3, ..., alpha^15.
    function automatic void build_gen_poly();
        int         mp [0:9];
        int         root;
        logic [P:0] acc;
        logic [P:0] nxt;
        acc = 1;
        for (int m = 1; m < 16; m += 2) begin
            for (int j = 0; j <= 9; j++) mp[j] = 0;
            mp[0] = 1;
            for (int k = 0; k < 9; k++) begin
                root = gf_exp[(m << k) % 511];
                for (int j = k + 1; j >= 1; j--) mp[j] = mp[j-1] ^ gmul(root, mp[j]);
                mp[0] = gmul(root, mp[0]);
            end
            nxt = '0;
            for (int j = 0; j <= 9; j++) if (mp[j] == 1) nxt = nxt ^ (acc << j);
            acc = nxt;
        end
        g_full = acc;
    endfunction

    function automatic bit syndrome_zero(input logic [N-1:0] c);
        int s;
        for (int i = 1; i <= 16; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) if (c[j]) s = s ^ gf_exp[(i * j) % 511];
            if (s != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] model_helper(input logic [N-1:0] r, input logic [K-1:0] s);
        logic [N-1:0] d;
        logic [N-1:0] gx;
        d  = {s, {P{1'b0}}};
        gx = {{(N-P-1){1'b0}}, g_full};
        for (int deg = N - 1; deg >= P; deg--) if (d[deg]) d = d ^ (gx << (deg - P));
        return r ^ {s, d[P-1:0]};
    endfunction

    function automatic logic [N-1:0] rand_resp();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v = {v[N-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [K-1:0] rand_sec();
        logic [K-1:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v = {v[K-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic check_output(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves start low at the negedge after the sampling edge.
    task automatic apply_stimulus(input logic [N-1:0] r, input logic [K-1:0] s);
        txn_t t;
        t.exp_helper  = model_helper(r, s);
        t.resp        = r;
        t.start_cycle = cycle + 1;
        sb_q.push_back(t);
        start    = 1'b1;
        response = r;
        secret   = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL ready_timeout: ready=%b after %0d cycles, required 1", ready, n);
        end
    endtask

    // Monitor: every rising ready retires the oldest outstanding request.
    initial begin
        logic ready_prev;
        txn_t t;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && ready_prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_ready: helper=%h with no request outstanding", helper);
                end else begin
                    t = sb_q.pop_front();
                    check_output("helper", helper, t.exp_helper);
                    check_output("latency", N'(cycle - t.start_cycle), N'(25));
                    check_output("syndrome_zero", N'(syndrome_zero(helper ^ t.resp)), N'(1));
                    check_output("busy_at_ready", N'(busy), '0);
                end
            end
            ready_prev = ready;
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] alt;
        logic [K-1:0] s;
        build_field();
        build_gen_poly();
        rst      = 1'b1;
        start    = 1'b0;
        response = '0;
        secret   = '0;

        for (int i = 0; i < 3; i++) begin
            start    = 1'b1;
            response = rand_resp();
            secret   = rand_sec();
            @(negedge clk);
            check_output("reset_helper", helper, '0);
            check_output("reset_busy_ready", N'({busy, ready}), '0);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_output("idle_after_reset", N'({busy, ready}), '0);

        apply_stimulus('0, '0);
        check_output("busy_after_start", N'({busy, ready}), N'(2'b10));
        wait_ready(40);

        alt = '0;
        for (int i = 0; i < N / 8; i++) alt = {alt[N-9:0], 8'hA5};
        apply_stimulus(alt, '0);
        wait_ready(40);
        check_output("zero_secret_passthrough", helper, alt);

        apply_stimulus('0, K'(1));
        wait_ready(40);
        check_output("single_bit", helper, {{(N-P-1){1'b0}}, 1'b1, g_full[P-1:0]});

        r = rand_resp();
        s = rand_sec();
        apply_stimulus(r, s);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        response = rand_resp();
        secret   = rand_sec();
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start    = 1'b1;
        response = rand_resp();
        secret   = rand_sec();
        @(negedge clk);
        start = 1'b0;
        wait_ready(40);

        apply_stimulus(rand_resp(), rand_sec());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_helper", helper, '0);
        check_output("abort_busy_ready", N'({busy, ready}), '0);
        apply_stimulus(rand_resp(), rand_sec());
        wait_ready(40);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply_stimulus(rand_resp(), rand_sec());
            wait_ready(40);
        end

        @(negedge clk);
        check_output("scoreboard_empty", N'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
